gate_exerciser: RTL and testbench
=================================

Name: gate_exerciser

Overview:
Self-checking stimulus driver for any 2-input combinational gate block in the library, such as the NOR gate. It drives `a`/`b` through all four input vectors, samples the gate's `y` response, and compares it against the truth table chosen by `gate_sel`. It reports pass, a per-vector failure mask and the observed truth table. It sits on the board/top level beside the gate under test, with buttons and LEDs attached.

Parameters:
SETTLE_CYCLES, 2, cycles to wait after driving a vector before sampling; must be ≥1.
SYNC_STAGES, 2, depth of the flop chain on `y`; must be ≥1.

Ports:
clk  input  1  single clock; all logic is rising-edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  level-sampled in IDLE; begins a run.
abort  input  1  synchronous; cancels the run in progress.
gate_sel  input  3  0=AND 1=OR 2=NAND 3=NOR 4=XOR 5=XNOR 6=BUF_A 7=NOT_A.
y  input  1  output of the gate under test; may change asynchronously.
a  output  1  stimulus to the gate.
b  output  1  stimulus to the gate.
busy  output  1  high during SETTLE/SAMPLE.
done  output  1  one-cycle pulse when a run completes.
pass  output  1  1 when the last completed run had no mismatch.
fail_vec  output  4  bit i set when vector i mismatched.
observed_tt  output  4  bit i = sampled `y` for vector i.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; a=b=busy=done=pass=0; fail_vec=observed_tt=0; vector index=0; sync chain cleared.
- Vector i (i=0..3): a=i[1], b=i[0]. Order is 00, 01, 10, 11.
- Expected bit i = TT[gate_sel][i]:
  - AND=0001→1000, i.e. 4'b1000; OR=4'b1110; NAND=4'b0111; NOR=4'b0001.
  - XOR=4'b0110; XNOR=4'b1001; BUF_A=4'b1100; NOT_A=4'b0011.
- `y` always passes through the SYNC_STAGES chain. Comparison uses y_sync only.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
  - IDLE: at an edge with start=1 and abort=0:
    - latch gate_sel;
    - clear fail_vec, observed_tt, pass;
    - a,b<=vector 0; idx<=0; cnt<=0;
    - go SETTLE.
  - SETTLE: cnt counts SETTLE_CYCLES+SYNC_STAGES cycles, then go SAMPLE.
  - SAMPLE (1 cycle): at its closing edge:
    - observed_tt[idx]<=y_sync;
    - fail_vec[idx]<=y_sync^expected[idx];
    - if idx<3: idx++, load the next vector onto a,b, cnt<=0, go SETTLE;
    - else: a=b=0, go DONE.
  - DONE (1 cycle): done=1; pass=(fail_vec==0), held until the next accepted start; go IDLE.
- Timing: each vector occupies SETTLE_CYCLES+SYNC_STAGES+1 cycles (5 with defaults).
  - a,b change at edges E0, E0+5, E0+10, E0+15, where E0 is the edge that accepts start.
  - done is high for the cycle after edge E0+20. Results are stable from E0+20.
- busy=1 in SETTLE and SAMPLE only.
- Boundary conditions:
  - start while busy: ignored.
  - gate_sel change mid-run: ignored (latched copy used).
  - abort in SETTLE/SAMPLE: next edge goes to IDLE; a=b=0; fail_vec=observed_tt=0; pass=0; no done pulse.
  - abort and start in the same IDLE cycle: abort wins, no run.
  - abort in DONE: done pulse still completes; results are kept.
  - start held high continuously: a new run begins at the edge after DONE.
  - rst_n low mid-run: immediate return to reset values. No run resumes after release until a new start.

Decomposition:
- Package gate_exerciser_pkg holds:
  - gate_sel code constants;
  - the 8×4 truth-table constant array;
  - the FSM state encoding;
  - function vec_ab(idx).
- One natural sub-module: sync_chain (parameterised SYNC_STAGES bit synchronizer, async active-low reset to 0).

Test Plan:
1. rst_n=0 with random inputs → all outputs 0, busy=0. After release with start=0 for 10 cycles, outputs stay 0.
2. gate_sel=3 (NOR), y model=~(a|b), start pulse at E0:
   - a,b = 00/01/10/11 at E0/+5/+10/+15;
   - done high 1 cycle after E0+20;
   - observed_tt=4'b0001, fail_vec=0, pass=1.
3. gate_sel=3, y model=~(a&b) (wrong gate) → observed_tt=4'b0111, fail_vec=4'b0110, pass=0.
4. gate_sel=4 (XOR), y stuck at 0 → observed_tt=4'b0000, fail_vec=4'b0110, pass=0. Then stuck at 1 → fail_vec=4'b1001.
5. Abort while idx=2 → busy=0 next cycle, a=b=0, no done, results cleared. A following start with NOR model passes.
6. Mid-run checks:
   - start re-pulsed and gate_sel changed to 0 mid-run → run unaffected, NOR result unchanged;
   - rst_n pulsed low mid-run → immediate reset values, no done pulse.

Source files
------------

// File: rtl/gate_exerciser_pkg.sv
// ---------------------------------------------------------------------------
// gate_exerciser_pkg
//   Shared definitions for the 2-input gate exerciser:
//     - gate_sel codes for the eight supported gate functions
//     - the 8x4 expected truth-table constant, indexed by gate_sel
//     - the exerciser FSM state encoding
//     - vec_ab(), which maps a vector index onto the {a, b} stimulus pair
// ---------------------------------------------------------------------------
package gate_exerciser_pkg;

  // gate_sel codes
  localparam logic [2:0] SEL_AND   = 3'd0;
  localparam logic [2:0] SEL_OR    = 3'd1;
  localparam logic [2:0] SEL_NAND  = 3'd2;
  localparam logic [2:0] SEL_NOR   = 3'd3;
  localparam logic [2:0] SEL_XOR   = 3'd4;
  localparam logic [2:0] SEL_XNOR  = 3'd5;
  localparam logic [2:0] SEL_BUF_A = 3'd6;
  localparam logic [2:0] SEL_NOT_A = 3'd7;

  // Bit i of each entry is the gate response to vector i, where vector i
  // drives a = i[1], b = i[0]. Entry order follows the gate_sel codes.
  localparam logic [3:0] TRUTH_TABLE [0:7] = '{
    4'b1000,  // AND
    4'b1110,  // OR
    4'b0111,  // NAND
    4'b0001,  // NOR
    4'b0110,  // XOR
    4'b1001,  // XNOR
    4'b1100,  // BUF_A
    4'b0011   // NOT_A
  };

  // Exerciser FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Stimulus pair for vector idx, returned as {a, b}. Vectors are walked in
  // binary order so a is the index MSB and b the LSB.
  function automatic logic [1:0] vec_ab(input logic [1:0] idx);
    return {idx[1], idx[0]};
  endfunction

endpackage

// File: rtl/gate_exerciser_sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
//   STAGES-deep flop chain that brings an asynchronous single-bit signal into
//   the clk domain. All flops clear to 0 on the asynchronous active-low reset.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   d      in   asynchronous input bit
//   q      out  synchronized copy of d, STAGES cycles later
// ---------------------------------------------------------------------------
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // A one-stage chain has no shift slice to take, so it gets its own branch;
  // otherwise new data enters at bit 0 and the synchronized value leaves the
  // top of the chain.
  generate
    if (STAGES == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          chain <= '0;
        end else begin
          chain <= d;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          chain <= '0;
        end else begin
          chain <= {chain[STAGES-2:0], d};
        end
      end
    end
  endgenerate

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gate_exerciser.sv
// ---------------------------------------------------------------------------
// gate_exerciser
//   Walks a 2-input gate under test through the four input vectors 00, 01,
//   10, 11, samples its synchronized response after a settle window, and
//   compares against the truth table selected by gate_sel (latched at start).
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   level-sampled in IDLE, begins a run
//   abort        in   cancels a run in progress (wins over start in IDLE)
//   gate_sel     in   truth-table select, see gate_exerciser_pkg codes
//   y            in   gate response, asynchronous to clk
//   a, b         out  stimulus to the gate under test
//   busy         out  high while vectors are being applied and sampled
//   done         out  one-cycle pulse when a run completes
//   pass         out  last completed run had no mismatch
//   fail_vec     out  bit i set when vector i mismatched
//   observed_tt  out  bit i is the sampled response to vector i
//
// Each vector occupies SETTLE_CYCLES + SYNC_STAGES cycles of SETTLE plus one
// cycle of SAMPLE, so the whole y path (gate delay plus synchronizer) has
// flushed before the sample is taken.
// ---------------------------------------------------------------------------
module gate_exerciser
  import gate_exerciser_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] gate_sel,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [3:0] observed_tt
);

  localparam int WAIT_CYCLES = SETTLE_CYCLES + SYNC_STAGES;
  localparam int CNT_W       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t           state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       sel_q;
  logic             y_sync;
  logic [3:0]       expected_tt;
  logic             mismatch;
  logic [3:0]       fail_next;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync_chain (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (y),
    .q    (y_sync)
  );

  assign expected_tt = TRUTH_TABLE[sel_q];
  assign mismatch    = y_sync ^ expected_tt[idx];

  // fail_vec as it will look after the current sample lands; pass on the
  // final vector is decided from this so it is valid in the done cycle.
  always_comb begin
    fail_next      = fail_vec;
    fail_next[idx] = mismatch;
  end

  // Exerciser FSM. All outputs are registered here so a, b, busy and done
  // change only on clock edges. done defaults low every cycle and is raised
  // only on the edge that closes the last sample, giving a one-cycle pulse
  // that coincides with ST_DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= 2'd0;
      cnt         <= '0;
      sel_q       <= 3'd0;
      a           <= 1'b0;
      b           <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_vec    <= 4'd0;
      observed_tt <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            sel_q       <= gate_sel;
            fail_vec    <= 4'd0;
            observed_tt <= 4'd0;
            pass        <= 1'b0;
            {a, b}      <= vec_ab(2'd0);
            idx         <= 2'd0;
            cnt         <= '0;
            busy        <= 1'b1;
            state       <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (abort) begin
            state       <= ST_IDLE;
            a           <= 1'b0;
            b           <= 1'b0;
            busy        <= 1'b0;
            pass        <= 1'b0;
            fail_vec    <= 4'd0;
            observed_tt <= 4'd0;
            idx         <= 2'd0;
            cnt         <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_SAMPLE: begin
          if (abort) begin
            state       <= ST_IDLE;
            a           <= 1'b0;
            b           <= 1'b0;
            busy        <= 1'b0;
            pass        <= 1'b0;
            fail_vec    <= 4'd0;
            observed_tt <= 4'd0;
            idx         <= 2'd0;
            cnt         <= '0;
          end else begin
            observed_tt[idx] <= y_sync;
            fail_vec         <= fail_next;
            if (idx != 2'd3) begin
              idx    <= idx + 2'd1;
              {a, b} <= vec_ab(idx + 2'd1);
              cnt    <= '0;
              state  <= ST_SETTLE;
            end else begin
              a     <= 1'b0;
              b     <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (fail_next == 4'd0);
              idx   <= 2'd0;
              state <= ST_DONE;
            end
          end
        end

        // Abort is deliberately not looked at here: a completed run keeps
        // its results and finishes its done pulse.
        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// ---------------------------------------------------------------------------
// tb_gate_exerciser
//   Table-driven bench for gate_exerciser. A behavioural gate model drives y
//   from a/b; each table row picks gate_sel and a gate model, and every run is
//   checked cycle by cycle for stimulus timing, busy/done and final results.
//   Hand-written sequences cover abort, abort+start, and reset mid-run.
// ---------------------------------------------------------------------------
module tb_gate_exerciser;
  import gate_exerciser_pkg::*;

  localparam int M_NOR  = 0;
  localparam int M_NAND = 1;
  localparam int M_ZERO = 2;
  localparam int M_ONE  = 3;
  localparam int M_AND  = 4;
  localparam int M_XOR  = 5;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       start    = 1'b0;
  logic       abort    = 1'b0;
  logic [2:0] gate_sel = 3'd0;
  logic       y;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_vec;
  logic [3:0] observed_tt;
  logic [12:0] outs;

  int model = M_NOR;
  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    logic [2:0] sel;
    int         mdl;
    logic [3:0] exp_tt;
    logic [3:0] exp_fail;
    logic       exp_pass;
    int         midrun;
  } run_vec_t;

  run_vec_t runs [12];

  gate_exerciser #(
    .SETTLE_CYCLES(2),
    .SYNC_STAGES  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .gate_sel   (gate_sel),
    .y          (y),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_vec   (fail_vec),
    .observed_tt(observed_tt)
  );

  always #5 clk = ~clk;

  assign outs = {a, b, busy, done, pass, fail_vec, observed_tt};

  // Behavioural gate under test, selected per run
  always_comb begin
    y = 1'b0;
    case (model)
      M_NOR:   y = ~(a | b);
      M_NAND:  y = ~(a & b);
      M_ZERO:  y = 1'b0;
      M_ONE:   y = 1'b1;
      M_AND:   y = a & b;
      M_XOR:   y = a ^ b;
      default: y = 1'b0;
    endcase
  end

  // Watchdog so a wedged run still ends with a report
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks_total++;
    if (actual === required) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  // Drives the run inputs (call at a negedge) and advances to the next edge
  task automatic applyStimulus(input logic [2:0] sel, input int mdl,
                               input logic st, input logic ab);
    gate_sel = sel;
    model    = mdl;
    start    = st;
    abort    = ab;
    @(posedge clk);
  endtask

  // Full run with per-cycle timing checks. midrun 1: start re-pulse and
  // gate_sel change mid-run; midrun 2: abort asserted during the done cycle.
  task automatic run_and_check(input run_vec_t rv, input string tag);
    logic [1:0] v;
    logic [3:0] exp_ctl;
    applyStimulus(rv.sel, rv.mdl, 1'b1, 1'b0);
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (rv.midrun == 1 && k == 7) begin
        start    = 1'b1;
        gate_sel = SEL_AND;
      end
      if (rv.midrun == 1 && k == 8) start = 1'b0;
      if (rv.midrun == 2 && k == 20) abort = 1'b1;
      if (rv.midrun == 2 && k == 21) abort = 1'b0;
      v       = (k < 20) ? 2'(k / 5) : 2'b00;
      exp_ctl = {v, (k < 20), (k == 20)};
      checkOutput($sformatf("%s a/b/busy/done k=%0d", tag, k),
                  {28'd0, a, b, busy, done}, {28'd0, exp_ctl});
      if (k == 0)
        checkOutput($sformatf("%s results cleared", tag),
                    {23'd0, pass, fail_vec, observed_tt}, 32'd0);
      if (k == 21)
        checkOutput($sformatf("%s results", tag),
                    {23'd0, pass, fail_vec, observed_tt},
                    {23'd0, rv.exp_pass, rv.exp_fail, rv.exp_tt});
    end
  endtask

  initial begin
    logic seen;

    runs[0]  = '{SEL_NOR,   M_NOR,  4'b0001, 4'b0000, 1'b1, 0};
    runs[1]  = '{SEL_NOR,   M_NAND, 4'b0111, 4'b0110, 1'b0, 0};
    runs[2]  = '{SEL_XOR,   M_ZERO, 4'b0000, 4'b0110, 1'b0, 0};
    runs[3]  = '{SEL_XOR,   M_ONE,  4'b1111, 4'b1001, 1'b0, 0};
    runs[4]  = '{SEL_AND,   M_AND,  4'b1000, 4'b0000, 1'b1, 0};
    runs[5]  = '{SEL_XNOR,  M_XOR,  4'b0110, 4'b1111, 1'b0, 0};
    runs[6]  = '{SEL_BUF_A, M_XOR,  4'b0110, 4'b1010, 1'b0, 0};
    runs[7]  = '{SEL_NOT_A, M_NOR,  4'b0001, 4'b0010, 1'b0, 0};
    runs[8]  = '{SEL_OR,    M_NAND, 4'b0111, 4'b1001, 1'b0, 0};
    runs[9]  = '{SEL_NAND,  M_NAND, 4'b0111, 4'b0000, 1'b1, 0};
    runs[10] = '{SEL_NOR,   M_NOR,  4'b0001, 4'b0000, 1'b1, 1};
    runs[11] = '{SEL_NOR,   M_NOR,  4'b0001, 4'b0000, 1'b1, 2};

    // Reset with random inputs, then idle release
    #2 rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start    = 1'($urandom_range(0, 1));
      abort    = 1'($urandom_range(0, 1));
      gate_sel = 3'($urandom_range(0, 7));
      model    = $urandom_range(0, 5);
      checkOutput($sformatf("reset outputs %0d", i), {19'd0, outs}, 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("idle after reset %0d", i), {19'd0, outs}, 32'd0);
    end

    // Table-driven full runs
    for (int r = 0; r < 12; r++) begin
      run_and_check(runs[r], $sformatf("run%0d", r));
    end

    // abort and start in the same idle cycle: no run
    applyStimulus(SEL_NOR, M_NOR, 1'b1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("abort+start busy/a/b", {29'd0, a, b, busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (busy || done) seen = 1'b1;
    end
    checkOutput("abort+start no activity", {31'd0, seen}, 32'd0);

    // abort while vector 2 is being settled
    applyStimulus(SEL_NOR, M_NOR, 1'b1, 1'b0);
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == 12) abort = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort outputs cleared", {19'd0, outs}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (busy || done) seen = 1'b1;
    end
    checkOutput("abort no done", {31'd0, seen}, 32'd0);
    run_and_check(runs[0], "after abort");

    // reset pulsed mid-run: immediate clear, nothing resumes
    applyStimulus(SEL_NOR, M_NOR, 1'b1, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("reset mid-run outputs", {19'd0, outs}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (busy || done) seen = 1'b1;
    end
    checkOutput("reset mid-run no resume", {31'd0, seen}, 32'd0);
    run_and_check(runs[0], "after reset");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
